// File: rtl/mem_lb_pkg.sv
// mem_lb_pkg: shared types, constants and helpers for the memory loopback
// controller and its skid FIFO.
//   DATA_W  - stream and RAM data width
//   ADDR_W  - RAM word-address width
//   DEPTH   - number of RAM words; addresses wrap from DEPTH-1 back to 0
//   BE_ALL  - byte enable driven on every access (full-word only)
//   state_e - controller FSM states
//   addr_inc() - word-address increment with wrap at DEPTH
package mem_lb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 6144;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_LASTW,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // DEPTH is not a power of two, so the wrap has to be explicit.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/mem_lb_skid_fifo.sv
// mem_lb_skid_fifo: 2-entry FIFO that absorbs RAM read data while the
// output stream is back-pressured.
//   clk, reset_n - clock, synchronous active-low reset (flushes the FIFO)
//   push, push_data - write one word (caller guarantees not full)
//   pop             - drop the head word (caller guarantees not empty)
//   head            - current head word (0 after reset)
//   count           - number of stored words, 0..2
module mem_lb_skid_fifo
  import mem_lb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem_q[rd_ptr];

endmodule

// File: rtl/mem_loopback_ctrl.sv
// mem_loopback_ctrl: Avalon-MM loopback engine in front of a single-port RAM.
// On start it writes len words from the input stream to consecutive
// (wrapping) RAM addresses beginning at base_addr, then reads them back in
// order onto the output stream.
//   control : start, base_addr, len in; busy, done, err out
//   input stream  : in_data, in_valid in; in_ready out
//   output stream : out_data, out_valid out; out_ready in
//   RAM (s1)      : mem_address, mem_chipselect, mem_write, mem_writedata,
//                   mem_byteenable, mem_clken out; mem_readdata in
//                   (read data valid one cycle after the read cycle)
// Stream handshakes: a word moves on a rising edge where valid and ready are
// both high; valid may be raised or dropped independently of ready.
module mem_loopback_ctrl
  import mem_lb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  state_e            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] pop_cnt;
  logic              wr_q;       // a write is on the bus this cycle
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_pend;    // mem_readdata carries a word this cycle
  logic              rd_issue;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic              start_ok;

  assign start_ok = (len != '0) && (len <= ADDR_W'(DEPTH)) &&
                    (base_addr < ADDR_W'(DEPTH));

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Words that will sit in the FIFO after this edge, assuming no further
  // pops. A new read lands one cycle later, so it needs this to be <= 1.
  assign occ = 3'(fifo_count) + 3'(rd_pend) - 3'(pop);

  // Reads are decided in the same cycle they appear on the bus; this is what
  // lets a single outstanding read plus a 2-deep FIFO sustain 1 word/clk.
  assign rd_issue = (state == ST_DRAIN) && (rd_cnt < len_q) && (occ < 3'd2);

  // Writes come from registers; reads override address/chipselect.
  // Writes and reads never overlap since writes end in LASTW.
  assign mem_chipselect = wr_q | rd_issue;
  assign mem_write      = wr_q;
  assign mem_address    = rd_issue ? rd_addr : wr_addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = BE_ALL;
  assign mem_clken      = 1'b1;

  mem_lb_skid_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_pend),
    .push_data (mem_readdata),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b0;
      len_q     <= '0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      pop_cnt   <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      rd_pend   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      wr_q    <= 1'b0;
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_addr <= addr_inc(rd_addr);
        rd_cnt  <= rd_cnt + 1'b1;
      end
      if (pop) begin
        pop_cnt <= pop_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              len_q    <= len;
              wr_addr  <= base_addr;
              rd_addr  <= base_addr;
              wr_cnt   <= '0;
              rd_cnt   <= '0;
              pop_cnt  <= '0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= ST_FILL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (in_valid && in_ready) begin
            wr_q      <= 1'b1;
            wr_addr_q <= wr_addr;
            wdata_q   <= in_data;
            wr_addr   <= addr_inc(wr_addr);
            wr_cnt    <= wr_cnt + 1'b1;
            if (wr_cnt == len_q - 1'b1) begin
              in_ready <= 1'b0;
              state    <= ST_LASTW;
            end
          end
        end
        ST_LASTW: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && (pop_cnt == len_q - 1'b1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
